// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable baud-rate tick generator for the UART.
// Produces a one-cycle rx_tick every eff_div clocks (16x oversampling rate)
// and a one-cycle tx_tick coincident with every 16th rx_tick (bit rate).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   i_divisor  clocks per rx_tick (0 stalls the generator, 1 ticks every cycle)
//   rx_tick    registered one-cycle oversample tick
//   tx_tick    registered one-cycle bit tick, coincident with every 16th rx_tick
//
// Optional feature macro: BAUD_GEN_DIV_SYNC_EN
//   When defined, i_divisor is sampled into a shadow register at each wrap,
//   so an interval already in progress always completes at the old divisor.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_divisor,
  output logic        rx_tick,
  output logic        tx_tick
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned OS_W  = 4;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] eff_div;
  logic [OS_W-1:0]  os_cnt;
  logic             stall_c;
  logic             wrap_c;

`ifdef BAUD_GEN_DIV_SYNC_EN
  logic [DIV_W-1:0] div_shadow;
  logic             first_q;

  // The first post-reset cycle bypasses the (still zero) shadow so the
  // first-tick latency matches the unsynchronised build.
  always_comb begin
    eff_div = first_q ? i_divisor : div_shadow;
  end

  // Shadow reloads at each wrap, on the first cycle after reset, and while
  // stalled so that a zero divisor can be replaced by a nonzero one.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_shadow <= '0;
      first_q    <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (first_q || wrap_c || stall_c) begin
        div_shadow <= i_divisor;
      end
    end
  end
`else
  always_comb begin
    eff_div = i_divisor;
  end
`endif

  // Wrap uses >= so a divisor lowered mid-count wraps at once instead of
  // running the counter through its full range.
  always_comb begin
    stall_c = (eff_div == '0);
    wrap_c  = !stall_c && (div_cnt >= (eff_div - DIV_W'(1)));
  end

  // Divide and oversample counters with registered tick outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else if (stall_c) begin
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else if (wrap_c) begin
      div_cnt <= '0;
      os_cnt  <= os_cnt + OS_W'(1);
      rx_tick <= 1'b1;
      tx_tick <= (os_cnt == OS_W'(15));
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: self-checking bench for uart_baud_gen.
// The reference is expressed in tick times: every rx_tick lands eff_div
// clocks after the previous one, and each tx_tick closes a group of 16.
module tb_uart_baud_gen;

  localparam int unsigned CLK_NS = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_divisor;
  logic        rx_tick;
  logic        tx_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rx_since_tx = 0;

  uart_baud_gen dut (
    .clk       (clk),
    .rst       (rst),
    .i_divisor (i_divisor),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; sample after the edge and track the 16-per-tx_tick rule.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_tick) rx_since_tx++;
    if (tx_tick) begin
      check("tx_with_rx", int'(rx_tick), 1);
      check("tx_ratio_monitor", rx_since_tx, 16);
      rx_since_tx = 0;
    end
  endtask

  task automatic wait_rx(input string tag, output int t);
    t = cyc;
    for (int k = 0; k < 1100; k++) begin
      step();
      if (rx_tick) begin
        t = cyc;
        return;
      end
    end
    check({tag, "_rx_timeout"}, 0, 1);
  endtask

  task automatic wait_tx(input string tag, output int t, output int nrx);
    t   = cyc;
    nrx = 0;
    for (int k = 0; k < 20000; k++) begin
      step();
      if (rx_tick) nrx++;
      if (tx_tick) begin
        t = cyc;
        return;
      end
    end
    check({tag, "_tx_timeout"}, 0, 1);
  endtask

  // Apply a divisor, let the disturbed interval pass, then check nper periods.
  task automatic measure(input string tag, input int div, input int nper);
    int a;
    int b;
    i_divisor = 16'(div);
    wait_rx(tag, a);
    for (int p = 0; p < nper; p++) begin
      wait_rx(tag, b);
      check(tag, (b - a) * CLK_NS, div * CLK_NS);
      a = b;
    end
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    int nrx;
    int old_div;
    int new_div;
    int cnt;

    rst       = 1'b1;
    i_divisor = 16'd325;

    // Reset held for 10 clocks: no ticks.
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_rx", int'(rx_tick), 0);
      check("rst_tx", int'(tx_tick), 0);
    end
    rst = 1'b0;
    cyc = 0;
    rx_since_tx = 0;

    // First tick in cycle N, one cycle wide, then period N.
    wait_rx("first_325", t0);
    check("first_rx_325", t0, 325);
    step();
    check("rx_width_325", int'(rx_tick), 0);
    wait_rx("per_325", t1);
    check("period_325_ns", (t1 - t0) * CLK_NS, 6500);

    measure("period_27_ns", 27, 3);

    // Ratio: 16 rx_ticks per tx_tick, tx period 16*N.
    i_divisor = 16'd100;
    wait_tx("ratio_sync", t0, nrx);
    wait_tx("ratio1", t1, nrx);
    check("ratio1_count", nrx, 16);
    check("ratio1_period_ns", (t1 - t0) * CLK_NS, 32000);
    wait_tx("ratio2", t2, nrx);
    check("ratio2_count", nrx, 16);
    check("ratio2_period_ns", (t2 - t1) * CLK_NS, 32000);

    // Dynamic 100 -> 50 without reset.
    measure("period_50_ns", 50, 3);

    // Minimum useful divisor: 40 ns period, one-cycle pulse.
    measure("period_2_ns", 2, 3);
    step();
    check("rx_width_2", int'(rx_tick), 0);

    // Zero divisor stalls; nonzero resumes.
    i_divisor = 16'd0;
    for (int i = 0; i < 600; i++) step();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rx_tick || tx_tick) cnt++;
    end
    check("stall_ticks", cnt, 0);
    measure("resume_10_ns", 10, 2);

    // Divisor 1: rx_tick every cycle.
    i_divisor = 16'd1;
    for (int i = 0; i < 30; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("div1_rx", int'(rx_tick), 1);
    end

    // Reset mid-count aborts with no residual tick; latency restarts.
    i_divisor = 16'd40;
    for (int i = 0; i < 57; i++) step();
    rst = 1'b1;
    step();
    check("midrst_rx", int'(rx_tick), 0);
    check("midrst_tx", int'(tx_tick), 0);
    rst = 1'b0;
    cyc = 0;
    rx_since_tx = 0;
    wait_rx("midrst_first", t0);
    check("midrst_first_rx", t0, 40);

    // Random divisors in [10,500].
    old_div = 40;
    for (int it = 0; it < 20; it++) begin
      new_div = int'($urandom_range(500, 10));
`ifdef BAUD_GEN_DIV_SYNC_EN
      // Change right after a tick: the interval in progress keeps the old N.
      wait_rx("rnd_a", t0);
      i_divisor = 16'(new_div);
      wait_rx("rnd_b", t1);
      check("rnd_keep_old_ns", (t1 - t0) * CLK_NS, old_div * CLK_NS);
      wait_rx("rnd_c", t2);
      check("rnd_new_ns", (t2 - t1) * CLK_NS, new_div * CLK_NS);
`else
      cnt = int'($urandom_range(old_div - 1, 0));
      for (int i = 0; i < cnt; i++) step();
      measure("rnd_period_ns", new_div, 2);
`endif
      old_div = new_div;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
